// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit period, data width.
// Build option: define UART_TX_PARITY_EN to add the even-parity state.
package uart_pkg;

    localparam int c_DEFAULT_CYCLES_PER_BIT = 434;
    localparam int c_DATA_W                 = 8;

    // One-hot state encoding, same style as the receiver.
    typedef enum logic [4:0] {
        s_IDLE   = 5'b00001,
        s_START  = 5'b00010,
        s_DATA   = 5'b00100,
`ifdef UART_TX_PARITY_EN
        s_PARITY = 5'b01000,
`endif
        s_STOP   = 5'b10000
    } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..c_CYCLES-1, wraps, and flags the last cycle.
module uart_bit_timer #(
    parameter int c_CYCLES = 434
) (
    input  logic i_CLK,
    input  logic i_RST_N,
    input  logic i_CLR,
    output logic o_TICK
);

    localparam int              c_W    = (c_CYCLES > 1) ? $clog2(c_CYCLES) : 1;
    localparam logic [c_W-1:0]  c_LAST = c_W'(c_CYCLES - 1);

    logic [c_W-1:0] cnt_q;
    logic [c_W-1:0] cnt_d;

    // Next count: clear on request or at terminal count, else increment.
    always_comb begin
        cnt_d = cnt_q + c_W'(1);
        if (i_CLR || (cnt_q == c_LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_TICK = (cnt_q == c_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 with a one-byte holding register for gapless frames.
// Build option: define UART_TX_PARITY_EN for 8E1 (even parity bit added).
module uart_tx
    import uart_pkg::*;
#(
    parameter int c_CYCLES_PER_BIT = c_DEFAULT_CYCLES_PER_BIT
) (
    input  logic                i_CLK,
    input  logic                i_RST_N,
    input  logic                i_TX_DV,
    input  logic [c_DATA_W-1:0] i_DATA_TX,
    output logic                o_TX_READY,
    output logic                o_SERIAL_DATA,
    output logic                o_TX_ACTIVE,
    output logic                o_TX_DONE
);

    tx_state_e           state_q, state_d;
    logic [c_DATA_W-1:0] shift_q, shift_d;
    logic [c_DATA_W-1:0] hold_data_q;
    logic                hold_vld_q, hold_vld_d;
    logic [2:0]          idx_q, idx_d;
    logic                serial_q, serial_d;
    logic                active_q, active_d;
    logic                done_q, done_d;
    logic                load;
    logic                accept;
    logic                timer_clr;
    logic                tick;

    uart_bit_timer #(.c_CYCLES(c_CYCLES_PER_BIT)) u_timer (
        .i_CLK  (i_CLK),
        .i_RST_N(i_RST_N),
        .i_CLR  (timer_clr),
        .o_TICK (tick)
    );

    // Readiness comes from the registered flag, so accept and load never collide.
    assign accept = i_TX_DV && !hold_vld_q;

    // Next-state, line value and holding-register bookkeeping.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        serial_d  = 1'b1;
        done_d    = 1'b0;
        load      = 1'b0;
        timer_clr = 1'b0;
        case (state_q)
            s_IDLE: begin
                timer_clr = 1'b1;
                if (hold_vld_q) begin
                    load    = 1'b1;
                    state_d = s_START;
                end
            end
            s_START: begin
                serial_d = 1'b0;
                if (tick) begin
                    idx_d   = 3'd0;
                    state_d = s_DATA;
                end
            end
            s_DATA: begin
                serial_d = shift_q[idx_q];
                if (tick) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = s_PARITY;
`else
                        state_d = s_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            s_PARITY: begin
                serial_d = ^shift_q;
                if (tick) begin
                    state_d = s_STOP;
                end
            end
`endif
            s_STOP: begin
                serial_d = 1'b1;
                if (tick) begin
                    done_d = 1'b1;
                    if (hold_vld_q) begin
                        load      = 1'b1;
                        timer_clr = 1'b1;
                        state_d   = s_START;
                    end else begin
                        state_d = s_IDLE;
                    end
                end
            end
            default: begin
                state_d = s_IDLE;
            end
        endcase

        if (load) begin
            shift_d = hold_data_q;
        end

        hold_vld_d = hold_vld_q;
        if (load) begin
            hold_vld_d = 1'b0;
        end
        if (accept) begin
            hold_vld_d = 1'b1;
        end

        active_d = (state_q != s_IDLE);
    end

    // Control and output registers; reset forces the line high immediately.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q    <= s_IDLE;
            idx_q      <= 3'd0;
            hold_vld_q <= 1'b0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_vld_q <= hold_vld_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    // Data registers; contents are qualified by the control state.
    always_ff @(posedge i_CLK) begin
        shift_q <= shift_d;
        if (accept) begin
            hold_data_q <= i_DATA_TX;
        end
    end

    assign o_TX_READY    = !hold_vld_q;
    assign o_SERIAL_DATA = serial_q;
    assign o_TX_ACTIVE   = active_q;
    assign o_TX_DONE     = done_q;

endmodule
